// File: rtl/ysyx_25040111_arbiter_if.sv
// rtl/ysyx_25040111_arbiter_if.sv - IFU/LSU/io_master AXI signal bundle for the two-master arbiter
interface ysyx_25040111_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // IFU read channels
  logic              ifu_arvalid, ifu_arready;
  logic [ADDR_W-1:0] ifu_araddr;
  logic [7:0]        ifu_arlen;
  logic [2:0]        ifu_arsize;
  logic [1:0]        ifu_arburst;
  logic              ifu_rvalid, ifu_rready, ifu_rlast;
  logic [DATA_W-1:0] ifu_rdata;
  logic [1:0]        ifu_rresp;

  // LSU read channels
  logic              lsu_arvalid, lsu_arready;
  logic [ADDR_W-1:0] lsu_araddr;
  logic [7:0]        lsu_arlen;
  logic [2:0]        lsu_arsize;
  logic [1:0]        lsu_arburst;
  logic              lsu_rvalid, lsu_rready, lsu_rlast;
  logic [DATA_W-1:0] lsu_rdata;
  logic [1:0]        lsu_rresp;

  // LSU write channels
  logic              lsu_awvalid, lsu_awready;
  logic [ADDR_W-1:0] lsu_awaddr;
  logic [2:0]        lsu_awsize;
  logic              lsu_wvalid, lsu_wready, lsu_wlast;
  logic [DATA_W-1:0] lsu_wdata;
  logic [STRB_W-1:0] lsu_wstrb;
  logic              lsu_bvalid, lsu_bready;
  logic [1:0]        lsu_bresp;

  // Downstream SoC master port
  logic              io_master_awready, io_master_awvalid;
  logic [ADDR_W-1:0] io_master_awaddr;
  logic [3:0]        io_master_awid;
  logic [7:0]        io_master_awlen;
  logic [2:0]        io_master_awsize;
  logic [1:0]        io_master_awburst;
  logic              io_master_wready, io_master_wvalid, io_master_wlast;
  logic [DATA_W-1:0] io_master_wdata;
  logic [STRB_W-1:0] io_master_wstrb;
  logic              io_master_bready, io_master_bvalid;
  logic [1:0]        io_master_bresp;
  logic [3:0]        io_master_bid;
  logic              io_master_arready, io_master_arvalid;
  logic [ADDR_W-1:0] io_master_araddr;
  logic [3:0]        io_master_arid;
  logic [7:0]        io_master_arlen;
  logic [2:0]        io_master_arsize;
  logic [1:0]        io_master_arburst;
  logic              io_master_rready, io_master_rvalid, io_master_rlast;
  logic [1:0]        io_master_rresp;
  logic [DATA_W-1:0] io_master_rdata;
  logic [3:0]        io_master_rid;

  // Arbiter view
  modport slave (
    input  ifu_arvalid, ifu_araddr, ifu_arlen, ifu_arsize, ifu_arburst, ifu_rready,
    output ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp, ifu_rlast,
    input  lsu_arvalid, lsu_araddr, lsu_arlen, lsu_arsize, lsu_arburst, lsu_rready,
    output lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp, lsu_rlast,
    input  lsu_awvalid, lsu_awaddr, lsu_awsize, lsu_wvalid, lsu_wdata, lsu_wstrb, lsu_wlast, lsu_bready,
    output lsu_awready, lsu_wready, lsu_bvalid, lsu_bresp,
    input  io_master_awready, io_master_wready, io_master_bvalid, io_master_bresp, io_master_bid,
    input  io_master_arready, io_master_rvalid, io_master_rresp, io_master_rdata, io_master_rlast, io_master_rid,
    output io_master_awvalid, io_master_awaddr, io_master_awid, io_master_awlen, io_master_awsize, io_master_awburst,
    output io_master_wvalid, io_master_wdata, io_master_wstrb, io_master_wlast, io_master_bready,
    output io_master_arvalid, io_master_araddr, io_master_arid, io_master_arlen, io_master_arsize, io_master_arburst,
    output io_master_rready
  );

  // Environment view (masters upstream, SoC downstream)
  modport master (
    output ifu_arvalid, ifu_araddr, ifu_arlen, ifu_arsize, ifu_arburst, ifu_rready,
    input  ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp, ifu_rlast,
    output lsu_arvalid, lsu_araddr, lsu_arlen, lsu_arsize, lsu_arburst, lsu_rready,
    input  lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp, lsu_rlast,
    output lsu_awvalid, lsu_awaddr, lsu_awsize, lsu_wvalid, lsu_wdata, lsu_wstrb, lsu_wlast, lsu_bready,
    input  lsu_awready, lsu_wready, lsu_bvalid, lsu_bresp,
    output io_master_awready, io_master_wready, io_master_bvalid, io_master_bresp, io_master_bid,
    output io_master_arready, io_master_rvalid, io_master_rresp, io_master_rdata, io_master_rlast, io_master_rid,
    input  io_master_awvalid, io_master_awaddr, io_master_awid, io_master_awlen, io_master_awsize, io_master_awburst,
    input  io_master_wvalid, io_master_wdata, io_master_wstrb, io_master_wlast, io_master_bready,
    input  io_master_arvalid, io_master_araddr, io_master_arid, io_master_arlen, io_master_arsize, io_master_arburst,
    input  io_master_rready
  );
endinterface

// File: rtl/ysyx_25040111_arbiter.sv
// rtl/ysyx_25040111_arbiter.sv - IFU/LSU AXI4 read arbiter with LSU write pass-through; ARB_RR_EN selects round-robin
module ysyx_25040111_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                     clock,
  input logic                     reset,
  ysyx_25040111_arbiter_if.slave  bus
);
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_BUSY = 1'b1;

  logic [1:0] r_state_q, r_state_d;
  logic       grant_q, grant_d;
  logic [0:0] w_state_q, w_state_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       req_winner;
  logic       ar_tie;
`ifdef ARB_RR_EN
  // Holds the master to favour on the next tie; reset value 0 favours the IFU first.
  logic       last_grant_q, last_grant_d;
`endif

  // Routing is by grant, so response IDs are intentionally unused.
  logic unused_ids;
  assign unused_ids = ^{bus.io_master_bid, bus.io_master_rid};

  assign ar_tie = bus.ifu_arvalid & bus.lsu_arvalid;

  // Pick the winner among the currently requesting masters.
  always_comb begin
`ifdef ARB_RR_EN
    req_winner = ar_tie ? last_grant_q : bus.lsu_arvalid;
`else
    req_winner = bus.lsu_arvalid;
`endif
  end

  // Read FSM: one complete burst per grant, released only on the last beat.
  always_comb begin
    r_state_d = r_state_q;
    grant_d   = grant_q;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (r_state_q)
      R_IDLE: begin
        if (bus.ifu_arvalid || bus.lsu_arvalid) begin
          grant_d   = req_winner;
          r_state_d = R_ADDR;
`ifdef ARB_RR_EN
          if (ar_tie) last_grant_d = ~req_winner;
`endif
        end
      end
      R_ADDR: if (bus.io_master_arvalid && bus.io_master_arready) r_state_d = R_DATA;
      R_DATA: if (bus.io_master_rvalid && bus.io_master_rready && bus.io_master_rlast) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read channel muxing: AR from the granted master in R_ADDR, R back to it in R_DATA.
  always_comb begin
    bus.io_master_arvalid = 1'b0;
    bus.io_master_araddr  = {ADDR_W{1'b0}};
    bus.io_master_arid    = 4'd0;
    bus.io_master_arlen   = 8'd0;
    bus.io_master_arsize  = 3'd0;
    bus.io_master_arburst = 2'd0;
    bus.io_master_rready  = 1'b0;
    bus.ifu_arready = 1'b0;
    bus.lsu_arready = 1'b0;
    bus.ifu_rvalid  = 1'b0;
    bus.ifu_rdata   = {DATA_W{1'b0}};
    bus.ifu_rresp   = 2'd0;
    bus.ifu_rlast   = 1'b0;
    bus.lsu_rvalid  = 1'b0;
    bus.lsu_rdata   = {DATA_W{1'b0}};
    bus.lsu_rresp   = 2'd0;
    bus.lsu_rlast   = 1'b0;
    if (r_state_q == R_ADDR) begin
      bus.io_master_arid = {3'b000, grant_q};
      if (grant_q) begin
        bus.io_master_arvalid = bus.lsu_arvalid;
        bus.io_master_araddr  = bus.lsu_araddr;
        bus.io_master_arlen   = bus.lsu_arlen;
        bus.io_master_arsize  = bus.lsu_arsize;
        bus.io_master_arburst = bus.lsu_arburst;
        bus.lsu_arready       = bus.io_master_arready;
      end else begin
        bus.io_master_arvalid = bus.ifu_arvalid;
        bus.io_master_araddr  = bus.ifu_araddr;
        bus.io_master_arlen   = bus.ifu_arlen;
        bus.io_master_arsize  = bus.ifu_arsize;
        bus.io_master_arburst = bus.ifu_arburst;
        bus.ifu_arready       = bus.io_master_arready;
      end
    end else if (r_state_q == R_DATA) begin
      if (grant_q) begin
        bus.lsu_rvalid       = bus.io_master_rvalid;
        bus.lsu_rdata        = bus.io_master_rdata;
        bus.lsu_rresp        = bus.io_master_rresp;
        bus.lsu_rlast        = bus.io_master_rlast;
        bus.io_master_rready = bus.lsu_rready;
      end else begin
        bus.ifu_rvalid       = bus.io_master_rvalid;
        bus.ifu_rdata        = bus.io_master_rdata;
        bus.ifu_rresp        = bus.io_master_rresp;
        bus.ifu_rlast        = bus.io_master_rlast;
        bus.io_master_rready = bus.ifu_rready;
      end
    end
  end

  // Write FSM: single outstanding LSU write, AW and W each accepted exactly once.
  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (w_state_q)
      W_IDLE: if (bus.lsu_awvalid) w_state_d = W_BUSY;
      default: begin
        if (bus.io_master_awvalid && bus.io_master_awready) aw_done_d = 1'b1;
        if (bus.io_master_wvalid && bus.io_master_wready) w_done_d = 1'b1;
        if (bus.io_master_bvalid && bus.io_master_bready) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
    endcase
  end

  // Write channel pass-through while busy; done flags mask repeated valids from the LSU.
  always_comb begin
    bus.io_master_awvalid = 1'b0;
    bus.io_master_awaddr  = {ADDR_W{1'b0}};
    bus.io_master_awid    = 4'd0;
    bus.io_master_awlen   = 8'd0;
    bus.io_master_awsize  = 3'd0;
    bus.io_master_awburst = 2'b00;
    bus.io_master_wvalid  = 1'b0;
    bus.io_master_wdata   = {DATA_W{1'b0}};
    bus.io_master_wstrb   = {STRB_W{1'b0}};
    bus.io_master_wlast   = 1'b0;
    bus.io_master_bready  = 1'b0;
    bus.lsu_awready = 1'b0;
    bus.lsu_wready  = 1'b0;
    bus.lsu_bvalid  = 1'b0;
    bus.lsu_bresp   = 2'd0;
    if (w_state_q == W_BUSY) begin
      bus.io_master_awvalid = bus.lsu_awvalid & ~aw_done_q;
      bus.io_master_awaddr  = bus.lsu_awaddr;
      bus.io_master_awsize  = bus.lsu_awsize;
      bus.io_master_awburst = 2'b01;
      bus.lsu_awready       = bus.io_master_awready & ~aw_done_q;
      bus.io_master_wvalid  = bus.lsu_wvalid & ~w_done_q;
      bus.io_master_wdata   = bus.lsu_wdata;
      bus.io_master_wstrb   = bus.lsu_wstrb;
      bus.io_master_wlast   = bus.lsu_wlast;
      bus.lsu_wready        = bus.io_master_wready & ~w_done_q;
      bus.lsu_bvalid        = bus.io_master_bvalid;
      bus.lsu_bresp         = bus.io_master_bresp;
      bus.io_master_bready  = bus.lsu_bready;
    end
  end

  // State registers; reset aborts any transfer in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state_q <= R_IDLE;
      grant_q   <= 1'b0;
      w_state_q <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      r_state_q <= r_state_d;
      grant_q   <= grant_d;
      w_state_q <= w_state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end
endmodule

// File: tb/tb_ysyx_25040111_arbiter.sv
// tb/tb_ysyx_25040111_arbiter.sv - directed scoreboard bench for the IFU/LSU arbiter
module tb_ysyx_25040111_arbiter;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ysyx_25040111_arbiter_if bus ();
  ysyx_25040111_arbiter dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct packed {
    logic        lsu;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.ifu_arvalid = 0; bus.ifu_araddr = 0; bus.ifu_arlen = 0; bus.ifu_arsize = 3'd2; bus.ifu_arburst = 2'b01;
    bus.lsu_arvalid = 0; bus.lsu_araddr = 0; bus.lsu_arlen = 0; bus.lsu_arsize = 3'd2; bus.lsu_arburst = 2'b01;
    bus.ifu_rready = 1; bus.lsu_rready = 1;
    bus.lsu_awvalid = 0; bus.lsu_awaddr = 0; bus.lsu_awsize = 0;
    bus.lsu_wvalid = 0; bus.lsu_wdata = 0; bus.lsu_wstrb = 0; bus.lsu_wlast = 0; bus.lsu_bready = 1;
    bus.io_master_awready = 0; bus.io_master_wready = 0; bus.io_master_bvalid = 0;
    bus.io_master_bresp = 0; bus.io_master_bid = 0;
    bus.io_master_arready = 0; bus.io_master_rvalid = 0; bus.io_master_rresp = 0;
    bus.io_master_rdata = 0; bus.io_master_rlast = 0; bus.io_master_rid = 0;
  endtask

  function automatic logic [11:0] hs_vec();
    return {bus.ifu_arready, bus.lsu_arready, bus.ifu_rvalid, bus.lsu_rvalid,
            bus.lsu_awready, bus.lsu_wready, bus.lsu_bvalid, bus.io_master_arvalid,
            bus.io_master_rready, bus.io_master_awvalid, bus.io_master_wvalid, bus.io_master_bready};
  endfunction

  task automatic set_req(input bit lsu, input logic [31:0] addr, input logic [7:0] len);
    if (lsu) begin bus.lsu_arvalid = 1; bus.lsu_araddr = addr; bus.lsu_arlen = len; end
    else begin bus.ifu_arvalid = 1; bus.ifu_araddr = addr; bus.ifu_arlen = len; end
  endtask

  // Called at a negedge with the request already driven; plays the SoC side of one read burst.
  task automatic read_txn(input bit exp_lsu, input logic [31:0] exp_addr, input int beats,
                          input int served, input logic [1:0] resp, input logic [31:0] dbase);
    int n = 0;
    beat_t e, act;
    #1;
    while (bus.io_master_arvalid !== 1'b1 && n < 20) begin @(negedge clock); #1; n++; end
    chk("grant_latency", n, 1);
    chk("arid", bus.io_master_arid, {3'b000, exp_lsu});
    chk("araddr", bus.io_master_araddr, exp_addr);
    chk("arlen", bus.io_master_arlen, beats - 1);
    bus.io_master_arready = 1; #1;
    chk("arready_route", {bus.ifu_arready, bus.lsu_arready}, exp_lsu ? 2'b01 : 2'b10);
    @(negedge clock);
    bus.io_master_arready = 0;
    if (exp_lsu) bus.lsu_arvalid = 0; else bus.ifu_arvalid = 0;
    for (int i = 0; i < served; i++) begin
      bus.io_master_rvalid = 1; bus.io_master_rdata = dbase + i;
      bus.io_master_rresp = resp; bus.io_master_rlast = (i == beats - 1);
      e.lsu = exp_lsu; e.data = dbase + i; e.resp = resp; e.last = (i == beats - 1);
      sb.push_back(e);
      #1;
      chk("rready_fwd", bus.io_master_rready, 1);
      chk("one_rvalid", bus.ifu_rvalid ^ bus.lsu_rvalid, 1);
      act.lsu  = bus.lsu_rvalid;
      act.data = bus.lsu_rvalid ? bus.lsu_rdata : bus.ifu_rdata;
      act.resp = bus.lsu_rvalid ? bus.lsu_rresp : bus.ifu_rresp;
      act.last = bus.lsu_rvalid ? bus.lsu_rlast : bus.ifu_rlast;
      e = sb.pop_front();
      chk("beat", act, e);
      @(negedge clock);
    end
    if (served == beats) begin
      bus.io_master_rvalid = 1; bus.io_master_rlast = 0; #1;
      chk("idle_rready", bus.io_master_rready, 0);
      chk("idle_rvalid", {bus.ifu_rvalid, bus.lsu_rvalid}, 0);
      chk("turnaround", bus.io_master_arvalid, 0);
      bus.io_master_rvalid = 0;
    end
  endtask

  // Called at a negedge; LSU holds its valids until B to exercise the done masks.
  task automatic write_txn(input logic [1:0] bresp);
    int aw_hs = 0, w_hs = 0, b_hs = 0, awv = 0, wv = 0;
    bus.lsu_awvalid = 1; bus.lsu_awaddr = 32'h8000_0004; bus.lsu_awsize = 3'd2;
    bus.lsu_wvalid = 1; bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_wstrb = 4'hF; bus.lsu_wlast = 1;
    #1;
    chk("aw_latency", bus.io_master_awvalid, 0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      bus.io_master_awready = (c == 1);
      bus.io_master_wready  = (c == 4);
      bus.io_master_bvalid  = (c == 6);
      bus.io_master_bresp   = bresp;
      if (c == 7) begin bus.lsu_awvalid = 0; bus.lsu_wvalid = 0; end
      #1;
      if (bus.io_master_awvalid) begin
        awv++;
        chk("awaddr", bus.io_master_awaddr, 32'h8000_0004);
        chk("aw_attr", {bus.io_master_awid, bus.io_master_awlen, bus.io_master_awburst, bus.io_master_awsize},
            {4'h0, 8'h00, 2'b01, 3'd2});
      end
      if (bus.io_master_wvalid) begin
        wv++;
        chk("wbeat", {bus.io_master_wdata, bus.io_master_wstrb, bus.io_master_wlast}, {32'hDEAD_BEEF, 4'hF, 1'b1});
      end
      if (bus.io_master_awvalid && bus.io_master_awready) aw_hs++;
      if (bus.io_master_wvalid && bus.io_master_wready) w_hs++;
      if (bus.lsu_bvalid) begin b_hs++; chk("bresp", bus.lsu_bresp, bresp); end
    end
    chk("aw_handshakes", aw_hs, 1);
    chk("w_handshakes", w_hs, 1);
    chk("b_pulses", b_hs, 1);
    chk("awvalid_cycles", awv, 1);
    chk("wvalid_cycles", wv, 4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 0;
    repeat (2) @(negedge clock);
    #1;
    chk("reset_handshakes", hs_vec(), 12'h000);
    chk("reset_data", {bus.io_master_araddr, bus.ifu_rdata}, 64'h0);
    @(negedge clock); reset = 1;
    @(negedge clock);

    // IFU-only 4-beat INCR read
    set_req(0, 32'h3000_0000, 8'd3);
    read_txn(0, 32'h3000_0000, 4, 4, 2'b00, 32'h0000_1000);

    // Two ties in a row
    for (int t = 0; t < 2; t++) begin
      @(negedge clock);
      set_req(1, 32'h8000_1000, 8'd0);
      set_req(0, 32'h3000_0010, 8'd1);
`ifdef ARB_RR_EN
      if (t == 0) begin
        read_txn(0, 32'h3000_0010, 2, 2, 2'b00, 32'h0000_2000);
        read_txn(1, 32'h8000_1000, 1, 1, 2'b00, 32'h0000_3000);
      end else begin
        read_txn(1, 32'h8000_1000, 1, 1, 2'b00, 32'h0000_3000);
        read_txn(0, 32'h3000_0010, 2, 2, 2'b00, 32'h0000_2000);
      end
`else
      read_txn(1, 32'h8000_1000, 1, 1, 2'b00, 32'h0000_3000);
      read_txn(0, 32'h3000_0010, 2, 2, 2'b00, 32'h0000_2000);
`endif
    end

    // LSU single-beat SLVERR then IFU follow-up
    @(negedge clock);
    set_req(1, 32'h8000_2000, 8'd0);
    read_txn(1, 32'h8000_2000, 1, 1, 2'b10, 32'h0000_4000);
    @(negedge clock);
    set_req(0, 32'h3000_0020, 8'd0);
    read_txn(0, 32'h3000_0020, 1, 1, 2'b00, 32'h0000_5000);

    // LSU store alone
    @(negedge clock);
    write_txn(2'b00);

    // Reset mid-read after beat 2 of 4, with every input request active
    @(negedge clock);
    set_req(0, 32'h3000_0040, 8'd3);
    read_txn(0, 32'h3000_0040, 4, 2, 2'b00, 32'h0000_6000);
    bus.ifu_arvalid = 1; bus.lsu_arvalid = 1; bus.lsu_awvalid = 1; bus.lsu_wvalid = 1;
    bus.io_master_bvalid = 1; bus.io_master_arready = 1; bus.io_master_awready = 1; bus.io_master_wready = 1;
    reset = 0;
    #1;
    chk("midreset_handshakes", hs_vec(), 12'h000);
    repeat (2) @(negedge clock);
    #1;
    chk("midreset_hold", hs_vec(), 12'h000);
    @(negedge clock);
    clear_inputs();
    reset = 1;
    @(negedge clock);
    set_req(0, 32'h3000_0080, 8'd3);
    read_txn(0, 32'h3000_0080, 4, 4, 2'b00, 32'h0000_7000);

    // Concurrent LSU write and IFU 8-beat read (DECERR beats)
    @(negedge clock);
    set_req(0, 32'h3000_0100, 8'd7);
    fork
      write_txn(2'b00);
      read_txn(0, 32'h3000_0100, 8, 8, 2'b11, 32'h0000_8000);
    join
    @(negedge clock);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_25040111_arbiter.md
# ysyx_25040111_arbiter

Two-master AXI4 read/write arbiter sitting directly downstream of the instruction fetch unit (IFU) and the load/store unit (LSU), merging both onto the single `io_master` port toward the SoC. Read requests from both masters are arbitrated and served one complete burst at a time. The write channel is LSU-only and is passed through with one outstanding transaction. Response beats are routed back by the registered grant, not by ID.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset; 0 = reset asserted
- `ifu_arvalid`/`ifu_arready`  in/out  1/1  IFU read address handshake
- `ifu_araddr`, `ifu_arlen`, `ifu_arsize`, `ifu_arburst`  in  32/8/3/2  IFU read address attributes
- `ifu_rvalid`, `ifu_rready`  out/in  1/1  IFU read data handshake
- `ifu_rdata`, `ifu_rresp`, `ifu_rlast`  out  32/2/1  IFU read data beat
- `lsu_arvalid`/`lsu_arready`, `lsu_araddr`, `lsu_arlen`, `lsu_arsize`, `lsu_arburst`  same widths as IFU  LSU read address channel
- `lsu_rvalid`/`lsu_rready`, `lsu_rdata`, `lsu_rresp`, `lsu_rlast`  same widths as IFU  LSU read data channel
- `lsu_aw*` (`valid`/`ready`/`addr`/`size`), `lsu_w*` (`valid`/`ready`/`data`/`strb` 4/`last`), `lsu_b*` (`valid`/`ready`/`resp` 2)  LSU write channels
- `io_master_*`  mixed  AXI4 downstream port, identical signal set to the SoC master port (`awid`, `arid` 4; `awlen` 8; `awburst` 2)

## Operation
- Read FSM states:
  - `R_IDLE`:
    - Samples `ifu_arvalid` and `lsu_arvalid`.
    - If either is high, registers `grant` (0 = IFU, 1 = LSU) and moves to `R_ADDR`.
  - `R_ADDR`:
    - Forwards the granted master's AR fields to `io_master_ar*`, with `io_master_arid = {3'b0, grant}`.
    - Returns `io_master_arready` to the granted master only; the other master's `arready` stays 0.
    - On the AR handshake, moves to `R_DATA`.
  - `R_DATA`:
    - Routes `io_master_rvalid`, `rdata`, `rresp` and `rlast` to the granted master.
    - `io_master_rready` is the granted master's `rready`.
    - The non-granted master's `rvalid` is 0.
    - On `rvalid & rready & rlast`, returns to `R_IDLE`.
- Arbitration (fixed priority): on simultaneous requests, the LSU wins.
- Write FSM states:
  - `W_IDLE`: moves to `W_BUSY` on `lsu_awvalid`.
  - `W_BUSY`:
    - Passes AW and W straight through; `awid = 0`, `awlen = 0`, `awburst = 2'b01`.
    - Tracks `aw_done` and `w_done` flags.
    - Passes B through to the LSU; on the B handshake, clears the flags and returns to `W_IDLE`.
    - Once `aw_done` is set, `io_master_awvalid` is forced to 0; likewise `w_done` forces `io_master_wvalid` to 0.
- Read and write FSMs are independent; a read may proceed concurrently with an LSU write.
- `rresp`/`bresp` are forwarded unmodified, including errors (2'b10, 2'b11). A burst is released only on `rlast`, never early on error.
- `io_master_rid`/`bid` are ignored for routing.
- An `rvalid` arriving in `R_IDLE` or `R_ADDR` is not acknowledged (`io_master_rready = 0`).

## Timing
- Reset values:
  - FSMs in `R_IDLE`/`W_IDLE`, `grant = 0`, flags cleared.
  - All `*valid` and `*ready` outputs are 0. Data outputs are don't-care, but driven as 0.
- Assertion of `reset` mid-burst aborts immediately. Outstanding downstream beats are the SoC's responsibility.
- Grant latency:
  - A request seen in cycle N gives `io_master_arvalid = 1` in cycle N+1.
  - Bus turnaround is at least 1 idle cycle between the last-beat handshake and the next `io_master_arvalid`.
- R and B routing is combinational (0 added latency). AW/W forwarding adds 1 cycle (the `W_IDLE` → `W_BUSY` transition).
- A master must hold `arvalid` and its attributes stable until `arready`. The arbiter does not register them.
- `rlast` on a 1-beat transfer (`arlen = 0`) releases the bus the same as a burst.

## Configuration
- `ARB_RR_EN` defined:
  - Round-robin arbitration: the master not served last wins a tie.
  - Uses a 1-bit `last_grant` register, reset to 0.
- Not defined: fixed LSU-over-IFU priority; the `last_grant` register is absent.

## Test plan
- IFU-only 4-beat INCR read:
  - Stimulus: `ifu_araddr = 0x3000_0000`, `arlen = 3`.
  - Response: `io_master_arid = 0`, four beats reach the IFU, `ifu_rlast` on beat 4, FSM back in `R_IDLE` the next cycle.
- Simultaneous IFU and LSU requests in the same cycle:
  - Without `ARB_RR_EN`: the LSU is served first, then the IFU.
  - With `ARB_RR_EN`: after reset the IFU is served first; on a repeat tie the LSU is served.
- LSU read with `rresp = 2'b10` on a single beat: `lsu_rresp = 2'b10`, `lsu_rlast = 1`, bus released, a following IFU request is granted.
- LSU `sw` to `0x8000_0004`:
  - Stimulus: `wdata = 0xDEADBEEF`, `wstrb = 4'hF`, `wready` delayed 3 cycles after `awready`.
  - Response: exactly one AW and one W handshake, `lsu_bvalid` pulses once, `awvalid` is not reasserted.
- Reset asserted mid-read (after beat 2 of 4): all valids/readies are 0 while reset is low. After release, a new IFU request is granted normally.
- Concurrent LSU write and IFU 8-beat read: both complete, with no beat misrouted to the wrong master.
